// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared ISA and parameter definitions for the memory stage.
// Holds the default datapath width, the opcodes the stage decodes, the NOP
// word used for bubbles, and small opcode-classification helpers.
package mem_stage_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_LD  = 6'h20;  // load byte, sign-extended
    localparam logic [5:0] OP_LH  = 6'h21;  // load half, sign-extended
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_LW, OP_SW: ok = (lo == 2'b00);
            OP_LH, OP_SH: ok = !lo[0];
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory bus between the memory stage and the memory.
// master: mem_req, mem_we, mem_addr, mem_wdata, mem_be out; mem_ack, mem_rdata in.
// slave : mirror image, driven by the memory.
interface mem_stage_if #(
    parameter int WIDTH = mem_stage_pkg::WIDTH_DEF
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align -- combinational byte-lane logic for the memory stage.
// Inputs : op (opcode), addr_lo (effective address bits [1:0]),
//          st_data (store data), rdata (memory read data).
// Outputs: be/we/wdata (store lane steering; loads give be=1111, we=0),
//          ld_data (load data extracted and sign-extended).
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [5:0]       op,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] st_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       be,
    output logic             we,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ld_data
);
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        be      = 4'b1111;
        we      = 1'b0;
        wdata   = st_data;
        ld_data = rdata;

        case (op)
            OP_LH: ld_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            OP_LD: ld_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            OP_SW: we = 1'b1;
            OP_SH: begin
                we    = 1'b1;
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                // Replicate so the half lands on whichever lane is enabled.
                wdata = WIDTH'({2{st_data[15:0]}});
            end
            OP_SB: begin
                we    = 1'b1;
                be    = 4'b0001 << addr_lo;
                wdata = WIDTH'({4{st_data[7:0]}});
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage with a two-state access FSM.
// Ports: clk, rst (sync, active-high); upstream valid_in/IR_in/PC_in/Z_in/B_in
// and combinational stall back-pressure; registered write-back outputs
// valid_out/IR_out/PC_out/Z_out; single-cycle misalign and bus_err pulses;
// mem (mem_stage_if.master) carries the registered data-memory request.
// Non-memory ops pass through in one cycle; memory ops take >= 2 cycles and
// emit bubbles while the access is outstanding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             stall,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic             valid_out,
    output logic             misalign,
    output logic             bus_err,
    mem_stage_if.master      mem
);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;

    // Instruction held for the duration of an access.
    logic [WIDTH-1:0] ir_p0;
    logic [WIDTH-3:0] pc_p0;
    logic [WIDTH-1:0] z_p0;

    logic [5:0] op_in, op_sel;
    logic [1:0] lo_sel;
    logic       issue, misal_ev, pass, done, tmo;

    logic [3:0]       al_be;
    logic             al_we;
    logic [WIDTH-1:0] al_wdata, al_ld;

    assign op_in = IR_in[31:26];
    // In IDLE the aligner steers the incoming store; in ACCESS it extracts
    // load data for the held instruction.
    assign op_sel = (state == ACCESS) ? ir_p0[31:26] : op_in;
    assign lo_sel = (state == ACCESS) ? z_p0[1:0] : Z_in[1:0];

    mem_align #(.WIDTH(WIDTH)) u_align (
        .op      (op_sel),
        .addr_lo (lo_sel),
        .st_data (B_in),
        .rdata   (mem.mem_rdata),
        .be      (al_be),
        .we      (al_we),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = ACCESS;
            ACCESS:  if (done || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state == IDLE) && valid_in && (is_load(op_in) || is_store(op_in))
                   && is_aligned(op_in, Z_in[1:0]);
        misal_ev = (state == IDLE) && valid_in && (is_load(op_in) || is_store(op_in))
                   && !is_aligned(op_in, Z_in[1:0]);
        pass     = (state == IDLE) && valid_in && !(is_load(op_in) || is_store(op_in));
        done     = (state == ACCESS) && mem.mem_ack;
        tmo      = (state == ACCESS) && !mem.mem_ack && (cnt == CNT_LAST);
        stall    = issue || ((state == ACCESS) && !mem.mem_ack);
    end

    // ---- stage boundary: control and write-back registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out    <= 1'b0;
            IR_out       <= WIDTH'(NOP);
            PC_out       <= '0;
            Z_out        <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= '0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
            cnt          <= '0;
        end else begin
            misalign <= misal_ev;
            bus_err  <= tmo;

            if (pass) begin
                valid_out <= 1'b1;
                IR_out    <= IR_in;
                PC_out    <= PC_in;
                Z_out     <= Z_in;
            end else if (done) begin
                valid_out <= 1'b1;
                IR_out    <= ir_p0;
                PC_out    <= pc_p0;
                Z_out     <= is_load(ir_p0[31:26]) ? al_ld : z_p0;
            end else begin
                valid_out <= 1'b0;
                IR_out    <= WIDTH'(NOP);
                Z_out     <= '0;
            end

            if (issue) begin
                mem.mem_req <= 1'b1;
                mem.mem_we  <= al_we;
                mem.mem_be  <= al_be;
                cnt         <= '0;
            end else if (done || tmo) begin
                mem.mem_req <= 1'b0;
                mem.mem_we  <= 1'b0;
                mem.mem_be  <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ---- stage boundary: access datapath registers ----
    always_ff @(posedge clk) begin
        if (issue) begin
            ir_p0         <= IR_in;
            pc_p0         <= PC_in;
            z_p0          <= Z_in;
            mem.mem_addr  <= {Z_in[WIDTH-1:2], 2'b00};
            mem.mem_wdata <= al_wdata;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [31:0]   IR_in, Z_in, B_in;
    logic [29:0]   PC_in;
    logic          stall, valid_out, misalign, bus_err;
    logic [31:0]   IR_out, Z_out;
    logic [29:0]   PC_out;

    mem_stage_if #(.WIDTH(W)) mif ();

    mem_stage #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .IR_in(IR_in), .PC_in(PC_in),
        .Z_in(Z_in), .B_in(B_in), .stall(stall), .IR_out(IR_out), .PC_out(PC_out),
        .Z_out(Z_out), .valid_out(valid_out), .misalign(misalign), .bus_err(bus_err),
        .mem(mif.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] z;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; IR_in = '0; PC_in = '0; Z_in = '0; B_in = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        tick(); tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_out); end
        n_checks++; if (IR_out !== NOP) begin n_fail++; $display("FAIL rst_ir: got %h want %h", IR_out, NOP); end
        n_checks++; if (PC_out !== 30'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", PC_out); end
        n_checks++; if (Z_out !== 32'd0) begin n_fail++; $display("FAIL rst_z: got %h want 0", Z_out); end
        n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_be} !== 6'b0) begin n_fail++; $display("FAIL rst_mem: got req=%b we=%b be=%b want 0", mif.mem_req, mif.mem_we, mif.mem_be); end
        n_checks++; if ({misalign, bus_err} !== 2'b0) begin n_fail++; $display("FAIL rst_err: got misalign=%b bus_err=%b want 0", misalign, bus_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        valid_in = 1'b1; IR_in = {OP_ADD, 26'h0112233}; PC_in = 30'h40; Z_in = 32'h1234;
        sb.push_back('{IR_in, PC_in, Z_in});
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick();
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", valid_out); end
        else begin
            e = sb.pop_front();
            if ({IR_out, PC_out, Z_out} !== {e.ir, e.pc, e.z}) begin
                n_fail++; $display("FAIL alu_out: got ir=%h pc=%h z=%h want ir=%h pc=%h z=%h", IR_out, PC_out, Z_out, e.ir, e.pc, e.z);
            end
        end
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall2: got %b want 0", stall); end
        tick();
        n_checks++; if ({valid_out, IR_out, Z_out} !== {1'b0, NOP, 32'd0}) begin n_fail++; $display("FAIL alu_bubble: got v=%b ir=%h z=%h want v=0 ir=%h z=0", valid_out, IR_out, Z_out, NOP); end
    endtask

    task automatic test_loads();
        logic [5:0]  op_t[6] = '{OP_LD, OP_LW, OP_LH, OP_LH, OP_LD, OP_LD};
        logic [31:0] z_t[6]  = '{32'h103, 32'h200, 32'h202, 32'h204, 32'h101, 32'h102};
        logic [31:0] rd_t[6] = '{32'h80FFFFFF, 32'h89ABCDEF, 32'h80017FFF, 32'h80017FFF, 32'h12345678, 32'h00F00000};
        logic [31:0] ex_t[6] = '{32'hFFFFFF80, 32'h89ABCDEF, 32'hFFFF8001, 32'h00007FFF, 32'h00000056, 32'hFFFFFFF0};
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1; IR_in = {op_t[i], 26'h4C0 + 26'(i)}; PC_in = 30'h100 + 30'(i); Z_in = z_t[i];
            sb.push_back('{IR_in, PC_in, ex_t[i]});
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_issue[%0d]: got %b want 1", i, stall); end
            tick();
            valid_in = 1'b0;
            n_checks++;
            if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, valid_out} !== {1'b1, 1'b0, 4'hF, z_t[i] & 32'hFFFFFFFC, 1'b0}) begin
                n_fail++; $display("FAIL ld_req[%0d]: got req=%b we=%b be=%b addr=%h v=%b want req=1 we=0 be=1111 addr=%h v=0",
                                   i, mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, valid_out, z_t[i] & 32'hFFFFFFFC);
            end
            mif.mem_ack = 1'b1; mif.mem_rdata = rd_t[i];
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_ack[%0d]: got %b want 0", i, stall); end
            tick();
            mif.mem_ack = 1'b0; mif.mem_rdata = '0;
            n_checks++;
            if (valid_out !== 1'b1) begin n_fail++; $display("FAIL ld_valid[%0d]: got %b want 1", i, valid_out); end
            else begin
                e = sb.pop_front();
                if ({IR_out, PC_out, Z_out} !== {e.ir, e.pc, e.z}) begin
                    n_fail++; $display("FAIL ld_out[%0d]: got ir=%h pc=%h z=%h want ir=%h pc=%h z=%h", i, IR_out, PC_out, Z_out, e.ir, e.pc, e.z);
                end
            end
            n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL ld_req_drop[%0d]: got %b want 0", i, mif.mem_req); end
        end
    endtask

    task automatic test_stores();
        logic [5:0]  op_t[5] = '{OP_SH, OP_SW, OP_SB, OP_SB, OP_SH};
        logic [31:0] z_t[5]  = '{32'h202, 32'h300, 32'h103, 32'h101, 32'h200};
        logic [31:0] b_t[5]  = '{32'h0000ABCD, 32'hDEADBEEF, 32'h1234565A, 32'h000000C3, 32'hFFFF1357};
        logic [3:0]  be_t[5] = '{4'b1100, 4'b1111, 4'b1000, 4'b0010, 4'b0011};
        logic [31:0] wd_t[5] = '{32'hABCDABCD, 32'hDEADBEEF, 32'h5A5A5A5A, 32'hC3C3C3C3, 32'h13571357};
        int          dly_t[5] = '{3, 0, 1, 0, 2};
        int          stall_cnt;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; IR_in = {op_t[i], 26'h2A0 + 26'(i)}; PC_in = 30'h200 + 30'(i); Z_in = z_t[i]; B_in = b_t[i];
            sb.push_back('{IR_in, PC_in, z_t[i]});
            stall_cnt = 0;
            #1;
            if (stall) stall_cnt++;
            tick();
            valid_in = 1'b0; B_in = '0;
            n_checks++;
            if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_wdata, mif.mem_addr} !== {1'b1, 1'b1, be_t[i], wd_t[i], z_t[i] & 32'hFFFFFFFC}) begin
                n_fail++; $display("FAIL st_req[%0d]: got req=%b we=%b be=%b wd=%h addr=%h want req=1 we=1 be=%b wd=%h addr=%h",
                                   i, mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_wdata, mif.mem_addr, be_t[i], wd_t[i], z_t[i] & 32'hFFFFFFFC);
            end
            for (int k = 0; k <= dly_t[i]; k++) begin
                mif.mem_ack = (k == dly_t[i]);
                #1;
                if (stall) stall_cnt++;
                tick();
            end
            mif.mem_ack = 1'b0;
            n_checks++; if (stall_cnt != dly_t[i] + 1) begin n_fail++; $display("FAIL st_stall_cycles[%0d]: got %0d want %0d", i, stall_cnt, dly_t[i] + 1); end
            n_checks++;
            if (valid_out !== 1'b1) begin n_fail++; $display("FAIL st_valid[%0d]: got %b want 1", i, valid_out); end
            else begin
                e = sb.pop_front();
                if ({IR_out, PC_out, Z_out} !== {e.ir, e.pc, e.z}) begin
                    n_fail++; $display("FAIL st_out[%0d]: got ir=%h pc=%h z=%h want ir=%h pc=%h z=%h", i, IR_out, PC_out, Z_out, e.ir, e.pc, e.z);
                end
            end
            n_checks++; if ({mif.mem_req, mif.mem_we} !== 2'b00) begin n_fail++; $display("FAIL st_req_drop[%0d]: got req=%b we=%b want 0", i, mif.mem_req, mif.mem_we); end
        end
    endtask

    task automatic test_misalign();
        logic [5:0]  op_t[3] = '{OP_LW, OP_SH, OP_SW};
        logic [31:0] z_t[3]  = '{32'h101, 32'h201, 32'h302};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; IR_in = {op_t[i], 26'h155}; PC_in = 30'h300 + 30'(i); Z_in = z_t[i]; B_in = 32'h77;
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall[%0d]: got %b want 0", i, stall); end
            tick();
            valid_in = 1'b0;
            n_checks++;
            if ({misalign, mif.mem_req, valid_out, IR_out, Z_out} !== {1'b1, 1'b0, 1'b0, NOP, 32'd0}) begin
                n_fail++; $display("FAIL mis_pulse[%0d]: got mis=%b req=%b v=%b ir=%h z=%h want mis=1 req=0 v=0 ir=%h z=0",
                                   i, misalign, mif.mem_req, valid_out, IR_out, Z_out, NOP);
            end
            tick();
            n_checks++; if ({misalign, mif.mem_req} !== 2'b00) begin n_fail++; $display("FAIL mis_clear[%0d]: got mis=%b req=%b want 0", i, misalign, mif.mem_req); end
        end
    endtask

    task automatic test_timeout();
        valid_in = 1'b1; IR_in = {OP_LW, 26'h3AA}; PC_in = 30'h400; Z_in = 32'h400;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL tmo_stall: got %b want 1", stall); end
        for (int k = 1; k <= TMO; k++) begin
            tick();
            valid_in = 1'b0;
            n_checks++;
            if ({mif.mem_req, bus_err, valid_out, stall} !== 4'b1001) begin
                n_fail++; $display("FAIL tmo_wait[%0d]: got req=%b err=%b v=%b stall=%b want req=1 err=0 v=0 stall=1", k, mif.mem_req, bus_err, valid_out, stall);
            end
        end
        tick();
        n_checks++;
        if ({bus_err, mif.mem_req, valid_out, IR_out} !== {1'b1, 1'b0, 1'b0, NOP}) begin
            n_fail++; $display("FAIL tmo_err: got err=%b req=%b v=%b ir=%h want err=1 req=0 v=0 ir=%h", bus_err, mif.mem_req, valid_out, IR_out, NOP);
        end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        tick();
        mif.mem_ack = 1'b0;
        n_checks++;
        if ({bus_err, mif.mem_req, valid_out} !== 3'b000) begin
            n_fail++; $display("FAIL idle_ack_ignored: got err=%b req=%b v=%b want 0", bus_err, mif.mem_req, valid_out);
        end
    endtask

    task automatic test_reset_access();
        valid_in = 1'b1; IR_in = {OP_LW, 26'h0F0}; PC_in = 30'h500; Z_in = 32'h500;
        tick();
        valid_in = 1'b0;
        tick();
        n_checks++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL rsta_req: got %b want 1", mif.mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({valid_out, IR_out, PC_out, Z_out, mif.mem_req, mif.mem_we, mif.mem_be, misalign, bus_err} !== {1'b0, NOP, 30'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rsta_outs: got v=%b ir=%h pc=%h z=%h req=%b we=%b be=%b mis=%b err=%b want all reset",
                               valid_out, IR_out, PC_out, Z_out, mif.mem_req, mif.mem_we, mif.mem_be, misalign, bus_err);
        end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h11112222;
        tick();
        mif.mem_ack = 1'b0;
        n_checks++;
        if ({valid_out, mif.mem_req, bus_err, misalign} !== 4'b0000) begin
            n_fail++; $display("FAIL rsta_late_ack: got v=%b req=%b err=%b mis=%b want 0", valid_out, mif.mem_req, bus_err, misalign);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; IR_in = {OP_ADD, 26'h1000 + 26'(i)}; PC_in = 30'h600 + 30'(i); Z_in = 32'hA0000000 + 32'(i);
            sb.push_back('{IR_in, PC_in, Z_in});
            tick();
            n_checks++;
            if (valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_out); end
            else begin
                e = sb.pop_front();
                if ({IR_out, PC_out, Z_out} !== {e.ir, e.pc, e.z}) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: got ir=%h pc=%h z=%h want ir=%h pc=%h z=%h", i, IR_out, PC_out, Z_out, e.ir, e.pc, e.z);
                end
            end
        end
        valid_in = 1'b0;
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %b want 0", valid_out); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_access();
        test_back_to_back();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
